cpu_mem_arbiter: RTL and testbench

CPU_MEM_ARBITER -- requirements
Module: cpu_mem_arbiter

---
 rtl/cpu_mem_arbiter_if.sv | 52 +++++
 rtl/cpu_mem_arbiter.sv | 118 +++++++++++
 tb/tb_cpu_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_mem_arbiter_if : CPU / NI request ports and shared memory port bundle  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface cpu_mem_arbiter_if #(
  parameter int MEMORY_BUS_WIDTH = 32
);
  localparam int ADDR_WIDTH = MEMORY_BUS_WIDTH - 2;

  logic                        cpu_req;
  logic [ADDR_WIDTH-1:0]       cpu_addr;
  logic [MEMORY_BUS_WIDTH-1:0] cpu_wdata;
  logic [3:0]                  cpu_wb;
  logic                        cpu_gnt;
  logic [MEMORY_BUS_WIDTH-1:0] cpu_rdata;
  logic                        cpu_rvalid;

  logic                        ni_req;
  logic [ADDR_WIDTH-1:0]       ni_addr;
  logic [MEMORY_BUS_WIDTH-1:0] ni_wdata;
  logic [3:0]                  ni_wb;
  logic                        ni_gnt;
  logic [MEMORY_BUS_WIDTH-1:0] ni_rdata;
  logic                        ni_rvalid;

  logic                        mem_en;
  logic [ADDR_WIDTH-1:0]       mem_addr;
  logic [MEMORY_BUS_WIDTH-1:0] mem_wdata;
  logic [3:0]                  mem_wb;
  logic [MEMORY_BUS_WIDTH-1:0] mem_rdata;

  // Requesters plus memory: the environment around the arbiter.
  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_wb,
    output ni_req, ni_addr, ni_wdata, ni_wb,
    output mem_rdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid,
    input  ni_gnt, ni_rdata, ni_rvalid,
    input  mem_en, mem_addr, mem_wdata, mem_wb
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_wb,
    input  ni_req, ni_addr, ni_wdata, ni_wb,
    input  mem_rdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid,
    output ni_gnt, ni_rdata, ni_rvalid,
    output mem_en, mem_addr, mem_wdata, mem_wb
  );
endinterface
`default_nettype wire

// File: rtl/cpu_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_mem_arbiter : two-requester (CPU / NI) memory port arbiter with burst  |
// | limit. Define ARB_ROUND_ROBIN_EN to resolve idle ties round-robin.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module cpu_mem_arbiter #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int MAX_BURST        = 8
) (
  input wire logic         clock,
  input wire logic         reset,
  cpu_mem_arbiter_if.slave bus
);
  localparam int   ADDR_WIDTH = MEMORY_BUS_WIDTH - 2;
  localparam logic LS_CPU     = 1'b0;
  localparam logic LS_NI      = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    NI_OWN  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] burst_cnt;
  logic       last_served;
  logic       cpu_rd_pend;
  logic       ni_rd_pend;

  logic       cpu_acc;
  logic       ni_acc;
  logic       access;
  logic [8:0] burst_sum;
  logic       burst_hit;
  logic       tie_to_ni;

  assign cpu_acc   = bus.cpu_req && (state == CPU_OWN);
  assign ni_acc    = bus.ni_req  && (state == NI_OWN);
  assign access    = cpu_acc || ni_acc;
  // The current cycle's access counts toward the limit, so an owner gets exactly MAX_BURST.
  assign burst_sum = {1'b0, burst_cnt} + {8'd0, access};
  assign burst_hit = (burst_sum >= 9'(MAX_BURST));

`ifdef ARB_ROUND_ROBIN_EN
  assign tie_to_ni = (last_served == LS_CPU);
`else
  // last_served is tracked in both builds but only steers ties with round robin.
  assign tie_to_ni = last_served & 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.cpu_req && bus.ni_req) state_nxt = tie_to_ni ? NI_OWN : CPU_OWN;
        else if (bus.cpu_req)          state_nxt = CPU_OWN;
        else if (bus.ni_req)           state_nxt = NI_OWN;
      end
      CPU_OWN: begin
        if (!bus.cpu_req)                state_nxt = bus.ni_req ? NI_OWN : IDLE;
        else if (bus.ni_req && burst_hit) state_nxt = NI_OWN;
      end
      NI_OWN: begin
        if (!bus.ni_req)                  state_nxt = bus.cpu_req ? CPU_OWN : IDLE;
        else if (bus.cpu_req && burst_hit) state_nxt = CPU_OWN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      burst_cnt   <= 8'd0;
      last_served <= LS_NI;
      cpu_rd_pend <= 1'b0;
      ni_rd_pend  <= 1'b0;
    end else begin
      cpu_rd_pend <= cpu_acc && (bus.cpu_wb == 4'b0000);
      ni_rd_pend  <= ni_acc  && (bus.ni_wb  == 4'b0000);
      if (state_nxt != state) begin
        state     <= state_nxt;
        burst_cnt <= 8'd0;
        if (state_nxt == CPU_OWN)     last_served <= LS_CPU;
        else if (state_nxt == NI_OWN) last_served <= LS_NI;
      end else if (access && (burst_cnt != 8'(MAX_BURST))) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

  assign bus.cpu_gnt    = (state == CPU_OWN);
  assign bus.ni_gnt     = (state == NI_OWN);
  assign bus.cpu_rvalid = cpu_rd_pend;
  assign bus.ni_rvalid  = ni_rd_pend;
  // Read data follows the strobe by one cycle, so it is passed straight through.
  assign bus.cpu_rdata  = cpu_rd_pend ? bus.mem_rdata : {MEMORY_BUS_WIDTH{1'b0}};
  assign bus.ni_rdata   = ni_rd_pend  ? bus.mem_rdata : {MEMORY_BUS_WIDTH{1'b0}};

  always_comb begin
    bus.mem_en    = access;
    bus.mem_addr  = {ADDR_WIDTH{1'b0}};
    bus.mem_wdata = {MEMORY_BUS_WIDTH{1'b0}};
    bus.mem_wb    = 4'b0000;
    if (cpu_acc) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
      bus.mem_wb    = bus.cpu_wb;
    end else if (ni_acc) begin
      bus.mem_addr  = bus.ni_addr;
      bus.mem_wdata = bus.ni_wdata;
      bus.mem_wb    = bus.ni_wb;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_cpu_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_mem_arbiter : self-checking bench for cpu_mem_arbiter               |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cpu_mem_arbiter;
  localparam int MEMORY_BUS_WIDTH = 32;
  localparam int MAX_BURST        = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_TIE_NI = 1'b1;
`else
  localparam logic RR_TIE_NI = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] cpu_q[$];
  logic [31:0] ni_q[$];

  cpu_mem_arbiter_if #(.MEMORY_BUS_WIDTH(MEMORY_BUS_WIDTH)) bus ();

  cpu_mem_arbiter #(
    .MEMORY_BUS_WIDTH(MEMORY_BUS_WIDTH),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b10, a} ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: read data appears the cycle after a read strobe.
  always @(posedge clock) begin
    if (bus.mem_en && (bus.mem_wb == 4'b0000)) bus.mem_rdata <= mem_word(bus.mem_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid must match the oldest expected read.
  always @(negedge clock) begin
    if (bus.cpu_rvalid) begin
      if (cpu_q.size() == 0) check_eq("cpu_rvalid_unexpected", 64'd1, 64'd0);
      else                   check_eq("cpu_rdata", 64'(bus.cpu_rdata), 64'(cpu_q.pop_front()));
    end
    if (bus.ni_rvalid) begin
      if (ni_q.size() == 0) check_eq("ni_rvalid_unexpected", 64'd1, 64'd0);
      else                  check_eq("ni_rdata", 64'(bus.ni_rdata), 64'(ni_q.pop_front()));
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_all();
    bus.cpu_req = 1'b0;
    bus.ni_req  = 1'b0;
    bus.cpu_wb  = 4'b0000;
    bus.ni_wb   = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n_cpu;
    logic got_ni;
    idle_all();
    bus.cpu_addr  = '0;
    bus.ni_addr   = '0;
    bus.cpu_wdata = '0;
    bus.ni_wdata  = '0;
    bus.mem_rdata = '0;
    repeat (2) next_cycle();

    check_eq("rst_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
    check_eq("rst_ni_gnt", 64'(bus.ni_gnt), 64'd0);
    check_eq("rst_mem_en", 64'(bus.mem_en), 64'd0);
    check_eq("rst_rvalid", 64'({bus.cpu_rvalid, bus.ni_rvalid}), 64'd0);
    check_eq("rst_rdata", 64'({bus.cpu_rdata, bus.ni_rdata}), 64'd0);
    reset = 1'b0;

    // Tie from reset: CPU first in both builds.
    next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_wb = 4'hF; bus.cpu_addr = 30'h1;
    bus.ni_req  = 1'b1; bus.ni_wb  = 4'hF; bus.ni_addr  = 30'h2;
    sample();
    check_eq("tie0_no_gnt_yet", 64'({bus.cpu_gnt, bus.ni_gnt}), 64'd0);
    next_cycle(); sample();
    check_eq("tie1_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
    check_eq("tie1_ni_gnt", 64'(bus.ni_gnt), 64'd0);
    next_cycle(); idle_all();
    repeat (2) next_cycle();
    bus.cpu_req = 1'b1; bus.cpu_wb = 4'hF;
    bus.ni_req  = 1'b1; bus.ni_wb  = 4'hF;
    next_cycle(); sample();
    check_eq("tie2_ni_gnt", 64'(bus.ni_gnt), 64'(RR_TIE_NI));
    check_eq("tie2_cpu_gnt", 64'(bus.cpu_gnt), 64'(!RR_TIE_NI));
    next_cycle(); idle_all();
    repeat (2) next_cycle();

    // Single CPU read.
    bus.cpu_req = 1'b1; bus.cpu_addr = 30'h10; bus.cpu_wb = 4'b0000;
    sample();
    check_eq("rd0_mem_en", 64'(bus.mem_en), 64'd0);
    next_cycle(); sample();
    check_eq("rd1_cpu_gnt", 64'(bus.cpu_gnt), 64'd1);
    check_eq("rd1_mem_en", 64'(bus.mem_en), 64'd1);
    check_eq("rd1_mem_addr", 64'(bus.mem_addr), 64'h10);
    check_eq("rd1_mem_wb", 64'(bus.mem_wb), 64'd0);
    cpu_q.push_back(mem_word(30'h10));
    next_cycle(); bus.cpu_req = 1'b0;
    sample();
    check_eq("rd2_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
    check_eq("rd2_mem_en", 64'(bus.mem_en), 64'd0);

    // NI write then NI read.
    next_cycle();
    bus.ni_req = 1'b1; bus.ni_addr = 30'h20; bus.ni_wb = 4'b0011; bus.ni_wdata = 32'hDEADBEEF;
    next_cycle(); sample();
    check_eq("wr_ni_gnt", 64'(bus.ni_gnt), 64'd1);
    check_eq("wr_mem_en", 64'(bus.mem_en), 64'd1);
    check_eq("wr_mem_wb", 64'(bus.mem_wb), 64'h3);
    check_eq("wr_mem_wdata", 64'(bus.mem_wdata), 64'hDEADBEEF);
    check_eq("wr_mem_addr", 64'(bus.mem_addr), 64'h20);
    next_cycle(); bus.ni_wb = 4'b0000; bus.ni_addr = 30'h21;
    sample();
    check_eq("wr_no_ni_rvalid", 64'(bus.ni_rvalid), 64'd0);
    check_eq("nird_mem_addr", 64'(bus.mem_addr), 64'h21);
    ni_q.push_back(mem_word(30'h21));
    next_cycle(); idle_all();
    sample();
    check_eq("nird_ni_rvalid", 64'(bus.ni_rvalid), 64'd1);
    check_eq("nird_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    repeat (2) next_cycle();

    // Burst limit and handover read: CPU streams reads while NI waits.
    bus.cpu_req = 1'b1; bus.cpu_wb = 4'b0000; bus.cpu_addr = 30'h40;
    bus.ni_req  = 1'b1; bus.ni_wb  = 4'hF;    bus.ni_addr  = 30'h50; bus.ni_wdata = 32'h1234_5678;
    n_cpu  = 0;
    got_ni = 1'b0;
    for (int k = 0; k < 20; k++) begin
      sample();
      if (bus.ni_gnt) begin
        got_ni = 1'b1;
        check_eq("ho_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd1);
        check_eq("ho_ni_rvalid", 64'(bus.ni_rvalid), 64'd0);
        check_eq("ho_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
        check_eq("ho_mem_wb", 64'(bus.mem_wb), 64'hF);
        break;
      end
      if (bus.cpu_gnt && bus.mem_en) begin
        cpu_q.push_back(mem_word(bus.cpu_addr));
        n_cpu++;
      end
      next_cycle();
      bus.cpu_addr = bus.cpu_addr + 30'd1;
    end
    check_eq("burst_ni_granted", 64'(got_ni), 64'd1);
    check_eq("burst_cpu_accesses", 64'(n_cpu), 64'(MAX_BURST));
    next_cycle(); idle_all();
    repeat (2) next_cycle();

    // Reset one cycle after a CPU read access discards the pending read.
    bus.cpu_req = 1'b1; bus.cpu_addr = 30'h33; bus.cpu_wb = 4'b0000;
    next_cycle(); sample();
    check_eq("rr_acc_mem_en", 64'(bus.mem_en), 64'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    check_eq("rr_cpu_gnt", 64'(bus.cpu_gnt), 64'd0);
    check_eq("rr_cpu_rvalid", 64'(bus.cpu_rvalid), 64'd0);
    check_eq("rr_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
    check_eq("rr_mem_en", 64'(bus.mem_en), 64'd0);
    check_eq("rr_mem_wb_addr", 64'({bus.mem_wb, bus.mem_addr}), 64'd0);
    next_cycle(); sample();
    check_eq("rr_hold_mem_en", 64'(bus.mem_en), 64'd0);
    next_cycle(); idle_all();
    reset = 1'b0;
    repeat (4) next_cycle();

    check_eq("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    check_eq("ni_q_drained", 64'(ni_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
